// File: rtl/aes_ctr_source.sv
// aes_ctr_source
//   Feeds CTR-mode counter blocks into a pipelined AES-256 core with fixed
//   latency, and tracks each block so the cycle its keystream emerges on the
//   core's OUT is flagged with the block's issue index.
//
//   Ports
//     CLK, RST      clock, asynchronous active-high reset
//     START         job request, only looked at in IDLE
//     NONCE         upper 96 bits of every counter block
//     CTR_INIT      counter value of block 0
//     KEY_IN        job key
//     COUNT         number of blocks in the job (0 completes immediately)
//     HOLD          request a bubble instead of a block
//     STATE, KEY    to the core's STATE and KEY inputs
//     IN_VALID      STATE/KEY carry a real block this cycle
//     OUT_VALID     core OUT carries a result of this job this cycle
//     OUT_INDEX     issue index of the block whose result is on OUT
//     BUSY          accept through the last result
//     DONE          one-cycle completion pulse
//
//   Block 0 is issued on the accepting edge itself, so BUSY lasts exactly
//   COUNT + bubbles + LATENCY cycles. HOLD is sampled on the edge, so a bubble
//   shows on STATE/IN_VALID in the cycle after HOLD was high.
module aes_ctr_source #(
  parameter int LATENCY = 69,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [95:0]      NONCE,
  input  logic [31:0]      CTR_INIT,
  input  logic [255:0]     KEY_IN,
  input  logic [CNT_W-1:0] COUNT,
  input  logic             HOLD,
  output logic [127:0]     STATE,
  output logic [255:0]     KEY,
  output logic             IN_VALID,
  output logic             OUT_VALID,
  output logic [CNT_W-1:0] OUT_INDEX,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t             state_q,    state_d;
  logic [95:0]        nonce_q,    nonce_d;
  logic [31:0]        ctr_q,      ctr_d;
  logic [255:0]       key_q,      key_d;
  logic [CNT_W-1:0]   count_q,    count_d;
  logic [CNT_W-1:0]   issued_q,   issued_d;
  logic [CNT_W-1:0]   out_idx_q,  out_idx_d;
  logic [127:0]       blk_q,      blk_d;
  logic               in_valid_q, in_valid_d;
  logic [LATENCY-1:0] trk_q,      trk_d;
  logic               busy_q,     busy_d;
  logic               done_q,     done_d;

  always_comb begin
    state_d    = state_q;
    nonce_d    = nonce_q;
    ctr_d      = ctr_q;
    key_d      = key_q;
    count_d    = count_q;
    issued_d   = issued_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    blk_d      = '0;
    in_valid_d = 1'b0;
    // Tracker mirrors IN_VALID one-for-one; its last tap is OUT_VALID, so a
    // block seen on IN_VALID in cycle c is flagged in cycle c + LATENCY.
    trk_d      = {trk_q[LATENCY-2:0], in_valid_q};
    out_idx_d  = trk_q[LATENCY-1] ? out_idx_q + CNT_W'(1) : out_idx_q;

    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          if (COUNT != '0) begin
            nonce_d    = NONCE;
            key_d      = KEY_IN;
            count_d    = COUNT;
            blk_d      = {NONCE, CTR_INIT};
            in_valid_d = 1'b1;
            ctr_d      = CTR_INIT + 32'd1;
            issued_d   = CNT_W'(1);
            out_idx_d  = '0;
            busy_d     = 1'b1;
            state_d    = (COUNT == CNT_W'(1)) ? S_DRAIN : S_ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (!HOLD) begin
          blk_d      = {nonce_q, ctr_q};
          in_valid_d = 1'b1;
          ctr_d      = ctr_q + 32'd1;
          issued_d   = issued_q + CNT_W'(1);
          if (issued_d == count_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Results emerge in issue order, so the final one carries COUNT-1.
        if (trk_q[LATENCY-1] && (out_idx_q == count_q - CNT_W'(1))) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      nonce_q    <= '0;
      ctr_q      <= '0;
      key_q      <= '0;
      count_q    <= '0;
      issued_q   <= '0;
      out_idx_q  <= '0;
      blk_q      <= '0;
      in_valid_q <= 1'b0;
      trk_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      nonce_q    <= nonce_d;
      ctr_q      <= ctr_d;
      key_q      <= key_d;
      count_q    <= count_d;
      issued_q   <= issued_d;
      out_idx_q  <= out_idx_d;
      blk_q      <= blk_d;
      in_valid_q <= in_valid_d;
      trk_q      <= trk_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign STATE     = blk_q;
  assign KEY       = key_q;
  assign IN_VALID  = in_valid_q;
  assign OUT_VALID = trk_q[LATENCY-1];
  assign OUT_INDEX = out_idx_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

// File: doc/aes_ctr_source.md
Name: aes_ctr_source

Overview:
- Upstream stage for the 69-cycle pipelined AES-256 core (`top`: CLK, STATE, KEY, OUT).
- Accepts one CTR-mode job: 96-bit nonce, 32-bit initial counter, 256-bit key and block count.
- Issues one counter block per cycle into the core's STATE/KEY inputs, inserting bubbles while HOLD is asserted.
- Tracks each issued block through the core's fixed latency. Flags the cycle its keystream appears on the core's OUT, with a block index, and signals job completion.

Parameters:
- LATENCY, 69, core cycles from a block on STATE to its result on OUT.
- CNT_W, 16, width of block count and index.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  job request; sampled only in IDLE.
- NONCE  in  96  upper 96 bits of every counter block.
- CTR_INIT  in  32  counter value of block 0.
- KEY_IN  in  256  job key.
- COUNT  in  CNT_W  number of blocks to issue.
- HOLD  in  1  suppress issue this cycle; bubble instead.
- STATE  out  128  to core STATE.
- KEY  out  256  to core KEY.
- IN_VALID  out  1  STATE/KEY carry a real block this cycle.
- OUT_VALID  out  1  core OUT carries a job result this cycle.
- OUT_INDEX  out  CNT_W  index of the block whose result is on OUT.
- BUSY  out  1  high from accept until the last result has emerged.
- DONE  out  1  one-cycle pulse when the job completes.

Behaviour:
- Reset (async, any time): all outputs 0, state IDLE, valid tracker cleared. In-flight blocks are discarded and never flagged.
- All outputs are registered.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - START=1 and COUNT>0: latch NONCE, CTR_INIT, KEY_IN, COUNT. Go to ISSUE; BUSY=1 from the next cycle.
  - START=1 and COUNT=0: DONE pulses the next cycle. No block is issued and BUSY stays 0.
- ISSUE:
  - Each cycle with HOLD=0: STATE = {nonce, ctr}, IN_VALID=1, ctr increments, issued count increments.
  - ctr wraps 0xFFFFFFFF -> 0x00000000; the nonce is never altered.
  - HOLD=1: STATE=0, IN_VALID=0, ctr unchanged.
  - After the COUNT-th block, go to DRAIN.
- DRAIN: STATE=0, IN_VALID=0. Wait until the final block's OUT_VALID has been asserted.
- Completion: the cycle after the last OUT_VALID, DONE=1 for exactly one cycle, BUSY=0, state IDLE.
  - A new START is accepted in that same cycle, so a back-to-back job overlaps nothing.
- KEY holds the latched job key for the whole job, including DRAIN and bubbles. It is cleared to 0 only by reset.
- Tracker: LATENCY-deep shift register of IN_VALID. OUT_VALID is high exactly LATENCY cycles after the cycle IN_VALID was high for that block. Bubbles are preserved one-for-one.
- OUT_INDEX: 0 at job start, increments after each OUT_VALID, wraps mod 2^CNT_W. It equals the issue order.
- START while BUSY: ignored, with no effect on the current job.
- HOLD in IDLE or DRAIN: no effect.

Test Plan:
1. Single block: NONCE=0, CTR_INIT=0, KEY_IN=0, COUNT=1. STATE=0, IN_VALID=1 for one cycle. OUT_VALID exactly 69 cycles later with OUT_INDEX=0 and OUT equal to AES-256(0,0). DONE the next cycle.
2. Streaming: COUNT=500, HOLD=0, nonce/key from the stored vector set. IN_VALID continuous for 500 cycles. 500 OUT_VALID cycles, indices 0..499, each OUT matching reference ciphertext. BUSY high for exactly 500+69 cycles.
3. Bubbles: COUNT=8, HOLD asserted on issue cycles 2 and 5. The two bubbles reappear in OUT_VALID 69 cycles later, indices remain 0..7 contiguous, and ctr values on STATE are sequential with no skips.
4. Wrap: CTR_INIT=0xFFFFFFFE, COUNT=4. STATE low words are FFFFFFFE, FFFFFFFF, 00000000, 00000001, with the nonce unchanged.
5. Reset mid-job: COUNT=100, assert RST after 40 issued blocks. All outputs are 0 immediately, OUT_VALID never asserts for the discarded blocks, and DONE is not pulsed. A fresh START after release behaves as scenario 1.
6. Edge requests: COUNT=0 gives DONE one cycle later with no IN_VALID. START during BUSY is ignored. A START in the DONE cycle is accepted.
